// File: rtl/frame_stat_ret_pkg.sv
// -----------------------------------------------------------------------------
// frame_stat_ret_pkg
// Shared definitions for the frame statistics return stage: FSM state
// encoding, statistic mode codes and the 32-bit saturation level.
// -----------------------------------------------------------------------------
package frame_stat_ret_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SUM    = 2'd0;  // saturating sum of pixels
    localparam logic [1:0] MODE_CNT_GE = 2'd1;  // count of pixels >= threshold
    localparam logic [1:0] MODE_MAX    = 2'd2;  // maximum pixel value
    localparam logic [1:0] MODE_BEATS  = 2'd3;  // number of beats in frame

    localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/frame_stat_acc.sv
// -----------------------------------------------------------------------------
// frame_stat_acc
// 32-bit statistic accumulator. An init strobe starts a new frame from the
// current beat and captures mode/threshold; an update strobe folds the beat
// into the running result using the captured mode/threshold.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   init           first beat of a frame (uses live mode/threshold)
//   update         subsequent beat of a frame
//   mode           statistic select, captured on init
//   threshold      compare level for MODE_CNT_GE, captured on init
//   pix            pixel value of the current beat
//   result         running 32-bit statistic
// -----------------------------------------------------------------------------
module frame_stat_acc
    import frame_stat_ret_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             init,
    input  logic             update,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] threshold,
    input  logic [PIX_W-1:0] pix,
    output logic [31:0]      result
);

    logic [1:0]       mode_q;
    logic [PIX_W-1:0] thr_q;
    logic [31:0]      acc;

    logic [1:0]       mode_sel;
    logic [PIX_W-1:0] thr_sel;
    logic [31:0]      pix_ext;
    logic [31:0]      base;
    logic [31:0]      acc_nxt;
    logic             pix_ge;

    // Unsigned add that clamps at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? SAT_MAX : s[31:0];
    endfunction

    always_comb begin
        // The sop beat must already use the new frame's mode/threshold.
        mode_sel = init ? mode : mode_q;
        thr_sel  = init ? threshold : thr_q;
        pix_ext  = {{(32-PIX_W){1'b0}}, pix};
        pix_ge   = (pix >= thr_sel);
        // Starting from zero lets init and update share one datapath.
        base     = init ? 32'd0 : acc;
        acc_nxt  = base;
        case (mode_sel)
            MODE_SUM:    acc_nxt = sat_add(base, pix_ext);
            MODE_CNT_GE: acc_nxt = base + {31'd0, pix_ge};
            MODE_MAX:    acc_nxt = (pix_ext > base) ? pix_ext : base;
            MODE_BEATS:  acc_nxt = base + 32'd1;
            default:     acc_nxt = base;
        endcase
    end

    // ---- accumulator register stage ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= 32'd0;
            mode_q <= MODE_SUM;
            thr_q  <= '0;
        end else begin
            if (init || update) begin
                acc <= acc_nxt;
            end
            if (init) begin
                mode_q <= mode;
                thr_q  <= threshold;
            end
        end
    end

    assign result = acc;

endmodule

// File: rtl/frame_stat_ret.sv
// -----------------------------------------------------------------------------
// frame_stat_ret
// Reduces one sop/eop delimited pixel frame to a 32-bit statistic and holds
// it on ret_value (PIO in_port) until the next frame completes.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   pix_data          pixel value
//   pix_valid         beat valid
//   pix_sop/pix_eop   frame delimiters, qualified by pix_valid
//   pix_ready         stage accepts a beat (low only in PUBLISH)
//   mode, threshold   statistic select / compare level, sampled on sop
//   clr               clears sticky error and frame counter
//   ret_value         last completed frame result
//   ret_frames        completed-frame counter (wraps)
//   ret_err           sticky error (sop re-sync or overrun)
//   busy              high while accumulating a frame
// -----------------------------------------------------------------------------
module frame_stat_ret
    import frame_stat_ret_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int MAX_PIX = 2097152
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_valid,
    input  logic             pix_sop,
    input  logic             pix_eop,
    output logic             pix_ready,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] threshold,
    input  logic             clr,
    output logic [31:0]      ret_value,
    output logic [15:0]      ret_frames,
    output logic             ret_err,
    output logic             busy
);

    localparam logic [31:0] MAX_PIX_L = 32'(MAX_PIX);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] beat_cnt;
    logic [31:0] cnt_nxt;
    logic        accept;
    logic        acc_init;
    logic        acc_update;
    logic        err_set;
    logic        publish;
    logic [31:0] acc_result;

    assign pix_ready = (state != ST_PUBLISH);
    assign busy      = (state == ST_ACCUM);
    assign accept    = pix_valid & pix_ready;
    assign publish   = (state == ST_PUBLISH);

    frame_stat_acc #(
        .PIX_W (PIX_W)
    ) u_acc (
        .clk       (clk),
        .reset_n   (reset_n),
        .init      (acc_init),
        .update    (acc_update),
        .mode      (mode),
        .threshold (threshold),
        .pix       (pix_data),
        .result    (acc_result)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = beat_cnt;
        acc_init   = 1'b0;
        acc_update = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Beats without sop are silently dropped here.
                if (accept && pix_sop) begin
                    acc_init  = 1'b1;
                    cnt_nxt   = 32'd1;
                    state_nxt = pix_eop ? ST_PUBLISH : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    if (pix_sop) begin
                        // Re-sync: previous partial frame is abandoned.
                        err_set  = 1'b1;
                        acc_init = 1'b1;
                        cnt_nxt  = 32'd1;
                    end else begin
                        acc_update = 1'b1;
                        cnt_nxt    = beat_cnt + 32'd1;
                    end
                    state_nxt = pix_eop ? ST_PUBLISH : ST_ACCUM;
                end
            end
            ST_PUBLISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Frame still open at the beat limit: flag overrun and drop it.
        if (state_nxt == ST_ACCUM && cnt_nxt >= MAX_PIX_L) begin
            err_set   = 1'b1;
            state_nxt = ST_IDLE;
            cnt_nxt   = 32'd0;
        end
    end

    // ---- control / result register stage ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            beat_cnt   <= 32'd0;
            ret_value  <= 32'd0;
            ret_frames <= 16'd0;
            ret_err    <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= cnt_nxt;
            if (publish) begin
                ret_value <= acc_result;
            end
            // clr beats the increment; a new error beats clr.
            if (clr) begin
                ret_frames <= 16'd0;
            end else if (publish) begin
                ret_frames <= ret_frames + 16'd1;
            end
            if (err_set) begin
                ret_err <= 1'b1;
            end else if (clr) begin
                ret_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_stat_ret.sv
module tb_frame_stat_ret;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // Small instance: 8-bit pixels, short overrun limit
    logic [7:0]  pix_data;
    logic        pix_valid, pix_sop, pix_eop, clr;
    logic [1:0]  mode;
    logic [7:0]  threshold;
    logic        pix_ready, ret_err, busy;
    logic [31:0] ret_value;
    logic [15:0] ret_frames;

    // Wide instance: 16-bit pixels for saturation
    logic [15:0] b_data;
    logic        b_valid, b_sop, b_eop, b_clr;
    logic [1:0]  b_mode;
    logic [15:0] b_threshold;
    logic        b_ready, b_err, b_busy;
    logic [31:0] b_value;
    logic [15:0] b_frames;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_frames;

    frame_stat_ret #(.PIX_W(8), .MAX_PIX(8)) dut (
        .clk(clk), .reset_n(reset_n), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_sop(pix_sop), .pix_eop(pix_eop), .pix_ready(pix_ready), .mode(mode),
        .threshold(threshold), .clr(clr), .ret_value(ret_value),
        .ret_frames(ret_frames), .ret_err(ret_err), .busy(busy)
    );

    frame_stat_ret #(.PIX_W(16), .MAX_PIX(70000)) dut_wide (
        .clk(clk), .reset_n(reset_n), .pix_data(b_data), .pix_valid(b_valid),
        .pix_sop(b_sop), .pix_eop(b_eop), .pix_ready(b_ready), .mode(b_mode),
        .threshold(b_threshold), .clr(b_clr), .ret_value(b_value),
        .ret_frames(b_frames), .ret_err(b_err), .busy(b_busy)
    );

    // Reference statistic of a whole frame, straight from the mode definitions.
    function automatic logic [31:0] stat_model(input int m, input int thr, input int px[$]);
        longint acc;
        acc = 0;
        case (m)
            0: begin
                foreach (px[i]) acc += px[i];
                if (acc > 64'hFFFF_FFFF) acc = 64'hFFFF_FFFF;
            end
            1: foreach (px[i]) if (px[i] >= thr) acc++;
            2: foreach (px[i]) if (px[i] > acc) acc = px[i];
            default: acc = px.size();
        endcase
        return acc[31:0];
    endfunction

    // One beat presented for exactly one clock; returns 1 time unit after the edge.
    task automatic beat(input int d, input bit s, input bit e);
        pix_data  = 8'(d);
        pix_valid = 1'b1;
        pix_sop   = s;
        pix_eop   = e;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_sop   = 1'b0;
        pix_eop   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_tests++; if (ret_value !== 32'd0) begin n_fail++; $display("FAIL reset_value: got %0h want 0", ret_value); end
        n_tests++; if (ret_frames !== 16'd0) begin n_fail++; $display("FAIL reset_frames: got %0d want 0", ret_frames); end
        n_tests++; if (ret_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", ret_err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", pix_ready); end
        n_tests++; if (b_value !== 32'd0 || b_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wide: value=%0h ready=%b want 0/1", b_value, b_ready); end
    endtask

    task automatic test_sum();
        mode = 2'd0; threshold = 8'd0;
        beat(10, 1, 0); beat(20, 0, 0); beat(30, 0, 0);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sum_busy: got %b want 1", busy); end
        beat(40, 0, 1);
        n_tests++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL sum_ready_low: got %b want 0", pix_ready); end
        n_tests++; if (ret_value !== 32'd0) begin n_fail++; $display("FAIL sum_early: got %0d want 0", ret_value); end
        tick();
        n_tests++; if (ret_value !== 32'd100) begin n_fail++; $display("FAIL sum_value: got %0d want 100", ret_value); end
        n_tests++; if (ret_frames !== 16'd1) begin n_fail++; $display("FAIL sum_frames: got %0d want 1", ret_frames); end
        n_tests++; if (ret_err !== 1'b0 || pix_ready !== 1'b1) begin n_fail++; $display("FAIL sum_after: err=%b ready=%b want 0/1", ret_err, pix_ready); end
        exp_frames = 16'd1;
    endtask

    task automatic test_thr_max();
        mode = 2'd1; threshold = 8'd128;
        beat(127, 1, 0);
        mode = 2'd3; threshold = 8'd0;   // must be ignored until next sop
        beat(128, 0, 0); beat(255, 0, 0); beat(0, 0, 1); tick();
        n_tests++; if (ret_value !== 32'd2) begin n_fail++; $display("FAIL cnt_ge_value: got %0d want 2", ret_value); end
        mode = 2'd2;
        beat(5, 1, 0);
        mode = 2'd0;
        beat(200, 0, 0); beat(3, 0, 1); tick();
        n_tests++; if (ret_value !== 32'd200) begin n_fail++; $display("FAIL max_value: got %0d want 200", ret_value); end
        n_tests++; if (ret_frames !== 16'd3) begin n_fail++; $display("FAIL max_frames: got %0d want 3", ret_frames); end
    endtask

    task automatic test_resync_clr();
        mode = 2'd3;
        beat(7, 0, 0); beat(9, 0, 1);    // no sop: dropped
        tick();
        n_tests++; if (ret_err !== 1'b0 || busy !== 1'b0 || ret_frames !== 16'd3 || ret_value !== 32'd200) begin
            n_fail++; $display("FAIL drop_no_sop: err=%b busy=%b frames=%0d value=%0d want 0/0/3/200", ret_err, busy, ret_frames, ret_value);
        end
        beat(1, 1, 0); beat(2, 0, 0); beat(3, 1, 0);
        n_tests++; if (ret_err !== 1'b1) begin n_fail++; $display("FAIL resync_err: got %b want 1", ret_err); end
        beat(4, 0, 0); beat(5, 0, 1); tick();
        n_tests++; if (ret_value !== 32'd3 || ret_frames !== 16'd4) begin n_fail++; $display("FAIL resync_value: value=%0d frames=%0d want 3/4", ret_value, ret_frames); end
        clr = 1'b1; tick(); clr = 1'b0;
        n_tests++; if (ret_err !== 1'b0 || ret_frames !== 16'd0 || ret_value !== 32'd3) begin
            n_fail++; $display("FAIL clr: err=%b frames=%0d value=%0d want 0/0/3", ret_err, ret_frames, ret_value);
        end
        // clr together with a fresh re-sync error: error must remain
        beat(1, 1, 0);
        clr = 1'b1; beat(1, 1, 0); clr = 1'b0;
        n_tests++; if (ret_err !== 1'b1) begin n_fail++; $display("FAIL clr_vs_err: got %b want 1", ret_err); end
        // clr during PUBLISH: counter zeroed, value still published
        beat(1, 0, 1);
        clr = 1'b1; tick(); clr = 1'b0;
        n_tests++; if (ret_frames !== 16'd0 || ret_value !== 32'd2 || ret_err !== 1'b0) begin
            n_fail++; $display("FAIL clr_publish: frames=%0d value=%0d err=%b want 0/2/0", ret_frames, ret_value, ret_err);
        end
    endtask

    task automatic test_overrun();
        mode = 2'd0;
        beat(1, 1, 0);
        for (int i = 2; i <= 8; i++) beat(i, 0, 0);
        n_tests++; if (ret_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL overrun_flag: err=%b busy=%b want 1/0", ret_err, busy); end
        beat(9, 0, 0);
        tick();
        n_tests++; if (ret_value !== 32'd2 || ret_frames !== 16'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL overrun_hold: value=%0d frames=%0d busy=%b want 2/0/0", ret_value, ret_frames, busy);
        end
        mode = 2'd3;
        beat(8'hAA, 1, 1); tick();
        n_tests++; if (ret_value !== 32'd1 || ret_frames !== 16'd1 || ret_err !== 1'b1) begin
            n_fail++; $display("FAIL single_beat: value=%0d frames=%0d err=%b want 1/1/1", ret_value, ret_frames, ret_err);
        end
    endtask

    task automatic test_async_reset();
        mode = 2'd0;
        beat(50, 1, 0); beat(60, 0, 0);
        #3 reset_n = 1'b0;
        #1;
        n_tests++; if (ret_value !== 32'd0 || ret_frames !== 16'd0 || ret_err !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_reset: value=%0d frames=%0d err=%b busy=%b ready=%b want 0/0/0/0/1",
                               ret_value, ret_frames, ret_err, busy, pix_ready);
        end
        @(negedge clk); reset_n = 1'b1;
        tick();
        mode = 2'd3;
        beat(1, 1, 0); beat(2, 0, 1); tick();
        n_tests++; if (ret_value !== 32'd2 || ret_frames !== 16'd1 || ret_err !== 1'b0) begin
            n_fail++; $display("FAIL after_reset: value=%0d frames=%0d err=%b want 2/1/0", ret_value, ret_frames, ret_err);
        end
        exp_frames = 16'd1;
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            int m, thr, len;
            int px[$];
            logic [31:0] exp_v;
            m   = $urandom_range(0, 3);
            thr = $urandom_range(0, 255);
            len = $urandom_range(1, 8);
            px  = {};
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0: px.push_back(255);
                    1: px.push_back(0);
                    default: px.push_back($urandom_range(0, 255));
                endcase
            end
            if ($urandom_range(0, 3) == 0) beat($urandom_range(0, 255), 0, $urandom_range(0, 1));
            mode = 2'(m); threshold = 8'(thr);
            for (int i = 0; i < len; i++) begin
                if (i > 0) begin
                    mode = 2'($urandom_range(0, 3));
                    threshold = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 3) == 0) tick();
                end
                beat(px[i], i == 0, i == len - 1);
            end
            exp_v = stat_model(m, thr, px);
            exp_frames = exp_frames + 16'd1;
            n_tests++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want 0", f, pix_ready); end
            tick();
            n_tests++; if (ret_value !== exp_v || ret_frames !== exp_frames) begin
                n_fail++; $display("FAIL rand_frame[%0d] mode=%0d len=%0d: value=%0h frames=%0d want %0h/%0d",
                                   f, m, len, ret_value, ret_frames, exp_v, exp_frames);
            end
        end
        n_tests++; if (ret_err !== 1'b0) begin n_fail++; $display("FAIL rand_err: got %b want 0", ret_err); end
    endtask

    task automatic test_saturation();
        longint total;
        total = 64'd66000 * 64'd65535;
        if (total > 64'hFFFF_FFFF) total = 64'hFFFF_FFFF;
        b_mode = 2'd0; b_data = 16'hFFFF;
        for (int i = 0; i < 66000; i++) begin
            b_valid = 1'b1;
            b_sop   = (i == 0);
            b_eop   = (i == 65999);
            @(posedge clk); #1;
        end
        b_valid = 1'b0; b_sop = 1'b0; b_eop = 1'b0;
        n_tests++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL sat_ready: got %b want 0", b_ready); end
        tick();
        n_tests++; if (b_value !== total[31:0]) begin n_fail++; $display("FAIL sat_value: got %0h want %0h", b_value, total[31:0]); end
        n_tests++; if (b_err !== 1'b0 || b_frames !== 16'd1) begin n_fail++; $display("FAIL sat_status: err=%b frames=%0d want 0/1", b_err, b_frames); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        pix_data = '0; pix_valid = 1'b0; pix_sop = 1'b0; pix_eop = 1'b0;
        mode = '0; threshold = '0; clr = 1'b0;
        b_data = '0; b_valid = 1'b0; b_sop = 1'b0; b_eop = 1'b0;
        b_mode = '0; b_threshold = '0; b_clr = 1'b0;
        exp_frames = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        tick();
        test_reset();
        test_sum();
        test_thr_max();
        test_resync_clr();
        test_overrun();
        test_async_reset();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_stat_ret.md
Name: frame_stat_ret

Overview:
- Streaming statistics stage sitting directly upstream of the 32-bit HPS-readable return-value PIO.
- Consumes one pixel stream frame (sop/eop delimited) from the image-processing pipeline and reduces it to a single 32-bit result.
- Holds that result stable on ret_value, which drives the PIO in_port, until the next frame completes; software polls ret_value and status.

Parameters:
- PIX_W, 8, pixel data width in bits (1..16).
- MAX_PIX, 2097152, maximum beats per frame before an overrun error is flagged (must fit in 32 bits).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- pix_data  in  PIX_W  pixel value
- pix_valid  in  1  beat valid
- pix_sop  in  1  first beat of frame; qualified by pix_valid
- pix_eop  in  1  last beat of frame; qualified by pix_valid
- pix_ready  out  1  stage can accept a beat
- mode  in  2  statistic select; sampled on the accepted sop beat
- threshold  in  PIX_W  compare level for mode 1; sampled on the accepted sop beat
- clr  in  1  synchronous clear of sticky error and frame counter
- ret_value  out  32  last completed frame result (to PIO in_port)
- ret_frames  out  16  completed-frame counter, wraps at 16'hFFFF->0
- ret_err  out  1  sticky error flag
- busy  out  1  high while in ACCUM

Behaviour:
- Reset reset_n: asynchronous, active-low; clock clk, rising edge. Reset values: ret_value=0, ret_frames=0, ret_err=0, busy=0, pix_ready=1, FSM=IDLE, accumulator=0, beat count=0.
- Accept = pix_valid & pix_ready.
- FSM states: IDLE, ACCUM, PUBLISH.
  - IDLE: pix_ready=1. Accepted beat without sop is discarded, no error. Accepted sop latches mode/threshold, initialises accumulator with that beat, beat count=1.
    - If that beat also has eop: go to PUBLISH.
    - Otherwise: go to ACCUM.
  - ACCUM: busy=1, pix_ready=1. Accepted beat updates accumulator and beat count.
    - eop: go to PUBLISH.
    - sop (re-sync): set ret_err, restart accumulation with this beat, and stay in ACCUM (or go to PUBLISH if eop also set).
    - Beat count reaches MAX_PIX without eop: set ret_err, discard frame, go to IDLE; no publish.
  - PUBLISH: exactly one cycle, pix_ready=0. ret_value <= final accumulator, ret_frames += 1. Then go to IDLE.
- End-of-frame to ret_value latency: ret_value changes on the clock edge after the cycle following the eop beat, i.e. 2 clocks after eop is accepted.
- Statistic modes; all 32-bit unsigned, pixel zero-extended:
  - 0: saturating sum; clamps at 32'hFFFF_FFFF, never wraps.
  - 1: count of pixels >= threshold.
  - 2: maximum pixel value.
  - 3: beat count.
- mode/threshold changes mid-frame have no effect until the next sop.
- ret_value is only ever written in PUBLISH; it never shows partial values.
- clr: ret_err=0 and ret_frames=0 on the next edge. FSM, accumulator and ret_value are unaffected.
  - clr coincident with a new error: the error wins (ret_err=1).
  - clr coincident with PUBLISH: ret_frames=0, ret_value still updates.
- reset_n asserted mid-frame: partial frame lost, all outputs return to reset values.

Decomposition:
- Shared package: FSM state encoding (IDLE/ACCUM/PUBLISH), mode constants (MODE_SUM, MODE_CNT_GE, MODE_MAX, MODE_BEATS), and the 32'hFFFF_FFFF saturation constant.
- One natural sub-module, frame_stat_acc: the combinational/registered accumulator datapath. It takes init/update strobes, mode, threshold and pixel, and returns the 32-bit result. The FSM and handshake stay in the top module.

Test Plan:
- Mode 0, 4-beat frame with pixels 10,20,30,40 -> ret_value=100 exactly 2 clocks after eop accepted, ret_frames=1, ret_err=0, pix_ready low for one cycle.
- Mode 1, threshold=128, pixels 127,128,255,0 -> ret_value=2. Next frame in mode 2 with 5,200,3 -> ret_value=200. Mode change mid-frame is ignored.
- Mode 0, PIX_W=16, MAX_PIX=70000, 66000 beats of 16'hFFFF -> ret_value saturates at 32'hFFFF_FFFF with no wrap, ret_err=0.
- Beats before any sop are dropped; a sop mid-frame -> ret_err=1, and the result reflects only beats from the second sop (mode 3, 3 beats -> 3). clr -> ret_err=0, ret_frames=0, ret_value held.
- MAX_PIX=8, 9 beats without eop -> ret_err=1, FSM back in IDLE, ret_value and ret_frames unchanged. Single-beat sop+eop frame (mode 3) -> ret_value=1.
- reset_n pulsed low asynchronously mid-frame -> all outputs at reset values immediately. Following clean 2-beat mode 3 frame -> ret_value=2, ret_frames=1.
